data_format_pack: RTL

//  Generalised input packer ahead of the DDR2 write FIFO. Packs RATIO narrow

---
 rtl/data_format_pack.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/data_format_pack.sv
// Packs RATIO narrow input words into one wide output word behind a one-deep
// output register; partial groups close on din_last, flush or idle timeout.
module data_format_pack #(
    parameter int DI_WIDTH      = 32,
    parameter int RATIO         = 2,
    parameter bit MSB_FIRST     = 1'b1,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DI_WIDTH-1:0]       din,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic                      din_last,
    input  logic                      flush,
    output logic [DI_WIDTH*RATIO-1:0] dout,
    output logic [RATIO-1:0]          dout_keep,
    output logic                      dout_last,
    output logic                      dout_valid,
    input  logic                      dout_ready
);

    localparam int DO_WIDTH = DI_WIDTH * RATIO;
    localparam int CW       = $clog2(RATIO);
    localparam int IW       = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(FLUSH_TIMEOUT);

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [DI_WIDTH-1:0]   lane_q [RATIO];
    logic [DI_WIDTH-1:0]   lane_d [RATIO];
    logic [DO_WIDTH-1:0]   dout_q, dout_d;
    logic [RATIO-1:0]      keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;

    logic                  out_free;
    logic                  accept;
    logic                  flush_eff;
    logic                  timeout;
    logic                  close;
    logic [CW:0]           fill;
    logic [DI_WIDTH-1:0]   merged [RATIO];
    logic [DO_WIDTH-1:0]   packed_w;
    logic [RATIO-1:0]      keep_w;

    always_comb begin
        out_free  = ~valid_q | dout_ready;
        accept    = din_valid & out_free;
        flush_eff = flush | flush_pend_q;
        timeout   = (FLUSH_TIMEOUT != 0) && (idle_q == IDLE_MAX);

        close = 1'b0;
        if (accept) begin
            close = (cnt_q == LAST_LANE) | din_last | flush_eff;
        end else if (state_q == FILLING) begin
            // Without an accept a close still needs somewhere to put the beat.
            close = out_free & (flush_eff | timeout);
        end

        for (int i = 0; i < RATIO; i++) begin
            merged[i] = lane_q[i];
        end
        if (accept) begin
            merged[cnt_q] = din;
        end
        fill = {1'b0, cnt_q} + {{CW{1'b0}}, accept};

        packed_w = '0;
        keep_w   = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (MSB_FIRST) begin
                packed_w[DO_WIDTH-1-i*DI_WIDTH -: DI_WIDTH] = merged[i];
            end else begin
                packed_w[i*DI_WIDTH +: DI_WIDTH] = merged[i];
            end
            keep_w[i] = (i < int'(fill));
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idle_d       = idle_q;
        flush_pend_d = flush_pend_q;
        lane_d       = lane_q;
        dout_d       = dout_q;
        keep_d       = keep_q;
        last_d       = last_q;
        valid_d      = valid_q;

        if (close) begin
            state_d      = EMPTY;
            cnt_d        = '0;
            idle_d       = '0;
            flush_pend_d = 1'b0;
            for (int i = 0; i < RATIO; i++) begin
                lane_d[i] = '0;
            end
            dout_d  = packed_w;
            keep_d  = keep_w;
            last_d  = accept & din_last;
            valid_d = 1'b1;
        end else begin
            if (valid_q & dout_ready) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                lane_d[cnt_q] = din;
                cnt_d         = cnt_q + CW'(1);
                state_d       = FILLING;
                idle_d        = '0;
            end else if (state_q == FILLING) begin
                if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + IW'(1);
                end
                // A flush seen while the output is stalled is remembered.
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            cnt_q        <= '0;
            idle_q       <= '0;
            flush_pend_q <= 1'b0;
            lane_q       <= '{default: '0};
            dout_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            flush_pend_q <= flush_pend_d;
            lane_q       <= lane_d;
            dout_q       <= dout_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
            valid_q      <= valid_d;
        end
    end

    assign din_ready  = out_free;
    assign dout       = dout_q;
    assign dout_keep  = keep_q;
    assign dout_last  = last_q;
    assign dout_valid = valid_q;

endmodule
